// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer-width helper and usage type for the synchronous FIFO and its agents
package fifo_pkg;
  localparam int unsigned USAGE_MAX_W = 16;
  typedef logic [USAGE_MAX_W-1:0] usage_t;
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: MSB-wrap read/write pointers, accept logic and status flags for fifo_sync
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ALM_FULL_TH  = DEPTH - 1,
  parameter int unsigned ALM_EMPTY_TH = 1,
  localparam int unsigned PW = ptr_w(DEPTH),
  localparam int unsigned AW = PW - 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic          full_o,
  output logic          empty_o,
  output logic          alm_full_o,
  output logic          alm_empty_o,
  output logic [PW-1:0] usage_o
);
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  assign full_o      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty_o     = wr_ptr == rd_ptr;
  assign usage_o     = wr_ptr - rd_ptr;
  assign alm_full_o  = usage_o >= PW'(ALM_FULL_TH);
  assign alm_empty_o = usage_o <= PW'(ALM_EMPTY_TH);
  assign push_ok     = push_i && !full_o;
  assign pop_ok      = pop_i && !empty_o;
  assign wr_en       = push_ok && !flush_i;
  assign wr_addr     = wr_ptr[AW-1:0];
  assign rd_addr     = rd_ptr[AW-1:0];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o))
    else $warning("fifo_ptr_ctrl: push while full dropped");
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o))
    else $warning("fifo_ptr_ctrl: pop while empty ignored");
endmodule

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO with flip-flop storage, flush, and almost-full/empty flags
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ALM_FULL_TH  = DEPTH - 1,
  parameter int unsigned ALM_EMPTY_TH = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic                   pop_i,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   alm_full_o,
  output logic                   alm_empty_o,
  output logic [$clog2(DEPTH):0] usage_o
);
  localparam int unsigned AW = ptr_w(DEPTH) - 1;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_sync: DEPTH must be a power of two and at least 2");
  end
  if (ALM_EMPTY_TH >= ALM_FULL_TH || ALM_FULL_TH > DEPTH) begin : g_bad_th
    $error("fifo_sync: need 0 <= ALM_EMPTY_TH < ALM_FULL_TH <= DEPTH");
  end
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic          wr_en;
  logic [AW-1:0] wr_addr, rd_addr;
  fifo_ptr_ctrl #(
    .DEPTH       (DEPTH),
    .ALM_FULL_TH (ALM_FULL_TH),
    .ALM_EMPTY_TH(ALM_EMPTY_TH)
  ) u_ptr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .push_i     (push_i),
    .pop_i      (pop_i),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .alm_full_o (alm_full_o),
    .alm_empty_o(alm_empty_o),
    .usage_o    (usage_o)
  );
  // storage is deliberately unreset so flush and reset only move pointers
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= data_i;
  end
  assign data_o = mem[rd_addr];
endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: directed vectors against a queue model for fifo_sync at DEPTH=8
module tb_fifo_sync;
  logic       clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0, push_i = 1'b0, pop_i = 1'b0;
  logic [7:0] data_i = '0, data_o;
  logic       full_o, empty_o, alm_full_o, alm_empty_o;
  logic [3:0] usage_o;
  int         vectors = 0, miscompares = 0;
  logic [7:0] q[$];
  always #5 clk_i = ~clk_i;
  fifo_sync dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .push_i     (push_i),
    .data_i     (data_i),
    .pop_i      (pop_i),
    .data_o     (data_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .alm_full_o (alm_full_o),
    .alm_empty_o(alm_empty_o),
    .usage_o    (usage_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".usage"}, 32'(usage_o), q.size());
    chk({tag, ".empty"}, 32'(empty_o), 32'(q.size() == 0));
    chk({tag, ".full"}, 32'(full_o), 32'(q.size() == 8));
    chk({tag, ".alm_full"}, 32'(alm_full_o), 32'(q.size() >= 7));
    chk({tag, ".alm_empty"}, 32'(alm_empty_o), 32'(q.size() <= 1));
    if (q.size() > 0) chk({tag, ".data"}, 32'(data_o), 32'(q[0]));
  endtask
  task automatic cyc(input logic push, input logic pop, input logic flush, input logic [7:0] d, input string tag);
    bit was_empty, was_full;
    push_i = push; pop_i = pop; flush_i = flush; data_i = d;
    @(posedge clk_i);
    was_empty = q.size() == 0;
    was_full  = q.size() == 8;
    if (flush) q.delete();
    else begin
      if (pop && !was_empty) void'(q.pop_front());
      if (push && !was_full) q.push_back(d);
    end
    #1;
    push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0;
    check_all(tag);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "tb_fifo_sync timeout");
  end
  initial begin
    #3;
    check_all("in_reset");
    #4 rst_ni = 1'b1;
    check_all("post_reset");
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 1'b0, 8'(i), "fill");
    chk("fill.full", 32'(full_o), 1);
    chk("fill.usage8", 32'(usage_o), 8);
    cyc(1'b1, 1'b0, 1'b0, 8'hAA, "overflow");
    chk("overflow.usage", 32'(usage_o), 8);
    for (int i = 1; i <= 8; i++) begin
      chk("drain.head", 32'(data_o), i);
      cyc(1'b0, 1'b1, 1'b0, 8'h00, "drain");
    end
    chk("drain.empty", 32'(empty_o), 1);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, "underflow");
    chk("underflow.usage", 32'(usage_o), 0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h10 + i), "fill4");
    cyc(1'b1, 1'b1, 1'b0, 8'h14, "simul4");
    chk("simul4.usage", 32'(usage_o), 4);
    chk("simul4.head", 32'(data_o), 32'h11);
    for (int i = 5; i < 9; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h10 + i), "refill");
    chk("refill.full", 32'(full_o), 1);
    cyc(1'b1, 1'b1, 1'b0, 8'h55, "simul_full");
    chk("simul_full.usage", 32'(usage_o), 7);
    chk("simul_full.head", 32'(data_o), 32'h12);
    for (int i = 0; i < 7; i++) begin
      chk("drain7.head", 32'(data_o), 32'h12 + i);
      cyc(1'b0, 1'b1, 1'b0, 8'h00, "drain7");
    end
    chk("drain7.empty", 32'(empty_o), 1);
    cyc(1'b1, 1'b1, 1'b0, 8'h33, "simul_empty");
    chk("simul_empty.usage", 32'(usage_o), 1);
    chk("simul_empty.head", 32'(data_o), 32'h33);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'(8'h40 + i), "wrap_push");
      cyc((i % 3) == 0, 1'b1, 1'b0, 8'(8'h80 + i), "wrap_pop");
    end
    cyc(1'b0, 1'b0, 1'b1, 8'h00, "flush_clear");
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i), "pre_flush");
    chk("pre_flush.usage", 32'(usage_o), 5);
    cyc(1'b1, 1'b0, 1'b1, 8'h99, "flush_push");
    chk("flush_push.usage", 32'(usage_o), 0);
    chk("flush_push.empty", 32'(empty_o), 1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'hD0 + i), "pre_rst");
    #1 rst_ni = 1'b0;
    q.delete();
    #1;
    chk("async_rst.empty", 32'(empty_o), 1);
    chk("async_rst.usage", 32'(usage_o), 0);
    #1 rst_ni = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 8'h77, "after_rst");
    chk("after_rst.head", 32'(data_o), 32'h77);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
